serial_adder_ctrl: RTL and testbench

SERIAL_ADDER_CTRL -- requirements
Module: serial_adder_ctrl

---
 rtl/serial_adder_ctrl_pkg.sv | 13 +
 rtl/serial_adder_ctrl_fa_cell.sv | 24 ++
 rtl/serial_adder_ctrl.sv | 98 +++++++++
 tb/tb_serial_adder_ctrl.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/serial_adder_ctrl_pkg.sv
// Shared types and constants for the bit-serial adder controller.
// Holds the FSM state encoding and the default operand width.
package serial_adder_ctrl_pkg;

    localparam int DEFAULT_W = 8;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } state_t;

endpackage

// File: rtl/serial_adder_ctrl_fa_cell.sv
// 1-bit full adder built purely from 2-input nand gates.
// Combinational, no state, no flow control.
module fa_cell (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);

    logic n1, n2, n3, x1, n4, n5, n6;

    // Classic 9-gate form: x1 = a^b, sum = x1^cin, cout = ab | x1&cin.
    nand g1 (n1, a, b);
    nand g2 (n2, a, n1);
    nand g3 (n3, b, n1);
    nand g4 (x1, n2, n3);
    nand g5 (n4, x1, cin);
    nand g6 (n5, x1, n4);
    nand g7 (n6, cin, n4);
    nand g8 (sum, n5, n6);
    nand g9 (cout, n4, n1);

endmodule

// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder: {cout,sum} = a + b + cin, LSB first, one bit per cycle.
// Latency W+1 cycles from accept to done; start is ignored while busy.
module serial_adder_ctrl
    import serial_adder_ctrl_pkg::*;
#(
    parameter int W = DEFAULT_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         cin,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] sum,
    output logic         cout
);

    localparam int CW = (W > 1) ? $clog2(W) : 1;

    state_t         state;
    state_t         state_nxt;
    logic [W-1:0]   a_sr;
    logic [W-1:0]   b_sr;
    logic           carry;
    logic [CW-1:0]  cnt;
    logic           last;
    logic           fa_s;
    logic           fa_c;

    assign last = (cnt == CW'(W - 1));
    assign cout = carry;

    fa_cell u_fa (
        .a    (a_sr[0]),
        .b    (b_sr[0]),
        .cin  (carry),
        .sum  (fa_s),
        .cout (fa_c)
    );

    // Outputs decode from registered state only, so start never reaches them.
    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            IDLE: begin
                if (start) state_nxt = RUN;
            end
            RUN: begin
                busy = 1'b1;
                if (last) state_nxt = DONE;
            end
            DONE: begin
                busy      = 1'b1;
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            a_sr  <= '0;
            b_sr  <= '0;
            carry <= 1'b0;
            cnt   <= '0;
            sum   <= '0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: begin
                    if (start) begin
                        a_sr  <= a;
                        b_sr  <= b;
                        carry <= cin;
                        cnt   <= '0;
                        sum   <= '0;
                    end
                end
                RUN: begin
                    // New bit enters at the MSB so W shifts leave sum aligned.
                    sum   <= W'({fa_s, sum} >> 1);
                    carry <= fa_c;
                    a_sr  <= a_sr >> 1;
                    b_sr  <= b_sr >> 1;
                    if (!last) cnt <= cnt + CW'(1);
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Directed bench for serial_adder_ctrl at W=8 and W=1 with a result scoreboard.
module tb_serial_adder_ctrl;

    typedef struct {
        logic [7:0] sum;
        logic       cout;
        int         cyc;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    int         cyc = 0;
    int         checks = 0;
    int         errors = 0;
    int         done_cnt [2];

    logic       start8 = 1'b0;
    logic [7:0] a8 = '0, b8 = '0;
    logic       cin8 = 1'b0;
    logic       busy8, done8, cout8;
    logic [7:0] sum8;

    logic       start1 = 1'b0;
    logic [0:0] a1 = '0, b1 = '0;
    logic       cin1 = 1'b0;
    logic       busy1, done1, cout1;
    logic [0:0] sum1;

    exp_t q8[$];
    exp_t q1[$];

    serial_adder_ctrl #(.W(8)) u8 (
        .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8), .cin(cin8),
        .busy(busy8), .done(done8), .sum(sum8), .cout(cout8)
    );

    serial_adder_ctrl #(.W(1)) u1 (
        .clk(clk), .rst(rst), .start(start1), .a(a1), .b(b1), .cin(cin1),
        .busy(busy1), .done(done1), .sum(sum1), .cout(cout1)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (done8) begin
            exp_t e;
            done_cnt[0]++;
            if (q8.size() == 0) begin
                check("unexpected_done_w8", {31'd0, done8}, 32'd0);
            end else begin
                e = q8.pop_front();
                check("sum_w8", {24'd0, sum8}, {24'd0, e.sum});
                check("cout_w8", {31'd0, cout8}, {31'd0, e.cout});
                check("done_cycle_w8", cyc, e.cyc);
            end
        end
        if (done1) begin
            exp_t e;
            done_cnt[1]++;
            if (q1.size() == 0) begin
                check("unexpected_done_w1", {31'd0, done1}, 32'd0);
            end else begin
                e = q1.pop_front();
                check("sum_w1", {31'd0, sum1}, {31'd0, e.sum[0]});
                check("cout_w1", {31'd0, cout1}, {31'd0, e.cout});
                check("done_cycle_w1", cyc, e.cyc);
            end
        end
    end

    function automatic exp_t model(input logic [7:0] a, input logic [7:0] b, input logic c,
                                   input int w, input int done_cyc);
        exp_t e;
        logic [8:0] t;
        t = {1'b0, a} + {1'b0, b} + {8'd0, c};
        e.sum  = (w == 1) ? {7'd0, t[0]} : t[7:0];
        e.cout = (w == 1) ? t[1] : t[8];
        e.cyc  = done_cyc;
        return e;
    endfunction

    // Drives start for one cycle while the DUT is idle; accept edge is the next posedge.
    task automatic op8(input logic [7:0] a, input logic [7:0] b, input logic c);
        start8 = 1'b1; a8 = a; b8 = b; cin8 = c;
        q8.push_back(model(a, b, c, 8, cyc + 1 + 8));
        tick();
        start8 = 1'b0;
        a8 = 8'($urandom); b8 = 8'($urandom); cin8 = 1'($urandom);
    endtask

    task automatic op1(input logic a, input logic b, input logic c);
        start1 = 1'b1; a1 = a; b1 = b; cin1 = c;
        q1.push_back(model({7'd0, a}, {7'd0, b}, c, 1, cyc + 1 + 1));
        tick();
        start1 = 1'b0;
        a1 = 1'($urandom); b1 = 1'($urandom); cin1 = 1'($urandom);
    endtask

    task automatic wait_done(input int which, input int target);
        for (int i = 0; i < 40; i++) begin
            tick();
            if (done_cnt[which] >= target) break;
        end
        check("done_timeout", {31'd0, done_cnt[which] >= target}, 32'd1);
    endtask

    initial begin
        int n8;
        int k;
        done_cnt[0] = 0;
        done_cnt[1] = 0;

        // Reset state
        start8 = 1'b1; a8 = 8'hAA; b8 = 8'h55;
        tick(); tick();
        check("rst_busy", {31'd0, busy8}, 32'd0);
        check("rst_done", {31'd0, done8}, 32'd0);
        check("rst_sum", {24'd0, sum8}, 32'd0);
        check("rst_cout", {31'd0, cout8}, 32'd0);
        start8 = 1'b0;
        rst = 1'b0;
        tick();

        // Basic add, with sum cleared and busy raised on the accept edge
        n8 = 0;
        op8(8'h5A, 8'h3C, 1'b0);
        check("accept_sum_clear", {24'd0, sum8}, 32'd0);
        check("run_busy", {31'd0, busy8}, 32'd1);
        check("run_done_low", {31'd0, done8}, 32'd0);
        n8++; wait_done(0, n8);
        check("idle_busy", {31'd0, busy8}, 32'd0);
        check("hold_sum", {24'd0, sum8}, 32'h96);
        check("hold_cout", {31'd0, cout8}, 32'd0);

        // Carry propagation cases
        op8(8'hFF, 8'h01, 1'b0); n8++; wait_done(0, n8);
        op8(8'hFF, 8'hFF, 1'b1); n8++; wait_done(0, n8);

        // start re-pulsed at RUN cycle 3 must be ignored
        op8(8'h12, 8'h34, 1'b0);
        tick(); tick();
        start8 = 1'b1; a8 = 8'h01; b8 = 8'h01;
        tick();
        start8 = 1'b0;
        n8++; wait_done(0, n8);
        repeat (12) tick();
        check("single_done_pulse", done_cnt[0], n8);

        // Reset mid-RUN aborts; fresh op afterwards is correct
        op8(8'h77, 8'h11, 1'b1);
        repeat (3) tick();
        q8.delete();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("abort_busy", {31'd0, busy8}, 32'd0);
        check("abort_done", {31'd0, done8}, 32'd0);
        check("abort_sum", {24'd0, sum8}, 32'd0);
        check("abort_cout", {31'd0, cout8}, 32'd0);
        repeat (12) tick();
        check("abort_no_done", done_cnt[0], n8);
        op8(8'hC3, 8'h5E, 1'b1); n8++; wait_done(0, n8);

        // start held high: back-to-back ops every W+2 cycles
        k = cyc + 1;
        start8 = 1'b1; a8 = 8'h81; b8 = 8'h7F; cin8 = 1'b0;
        q8.push_back(model(8'h81, 8'h7F, 1'b0, 8, k + 8));
        q8.push_back(model(8'h0F, 8'hF0, 1'b1, 8, k + 10 + 8));
        q8.push_back(model(8'h33, 8'h44, 1'b1, 8, k + 20 + 8));
        tick();
        a8 = 8'h0F; b8 = 8'hF0; cin8 = 1'b1;
        repeat (10) tick();
        a8 = 8'h33; b8 = 8'h44; cin8 = 1'b1;
        repeat (10) tick();
        start8 = 1'b0;
        n8 += 3; wait_done(0, n8);
        check("held_queue_empty", q8.size(), 32'd0);

        // W=1 exhaustive
        for (int i = 0; i < 8; i++) begin
            logic [2:0] v;
            v = 3'(i);
            op1(v[2], v[1], v[0]);
            wait_done(1, i + 1);
        end
        check("w1_queue_empty", q1.size(), 32'd0);

        repeat (4) tick();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
